// File: rtl/switch_event_reporter.sv
// switch_event_reporter: turns a debounced switch level into press/short/long/release event bytes
module switch_event_reporter #(
    parameter int CLKS_PER_MS   = 25000,
    parameter int LONG_PRESS_MS = 500
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    output logic       o_Press_Pulse,
    output logic       o_Release_Pulse,
    output logic       o_Long_Press,
    output logic       o_Event_DV,
    output logic [7:0] o_Event_Byte,
    input  logic       i_Event_Ready,
    output logic       o_Overflow,
    input  logic       i_Clear_Overflow,
    output logic [7:0] o_Press_Count
);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [15:0] MS_LAST = 16'(LONG_PRESS_MS - 1);

    typedef enum logic [1:0] {IDLE, HELD_SHORT, HELD_LONG} state_t;

    state_t state, state_nx;
    logic prev, rise, fall, threshold;
    logic [PW-1:0] presc;
    logic [15:0] ms_count;
    logic push, pop, drop, accept;
    logic [7:0] push_byte, fifo0, fifo1;
    logic [1:0] count, level;

    assign rise = i_Switch & ~prev;
    assign fall = ~i_Switch & prev;
    // The threshold edge is the one that would bring the elapsed count to LONG_PRESS_MS*CLKS_PER_MS
    assign threshold = (presc == PRESC_LAST) && (ms_count == MS_LAST);

    assign pop = o_Event_DV & i_Event_Ready;
    assign drop = push & (count == 2'd2) & ~pop;
    assign accept = push & ~drop;
    assign level = count - {1'b0, pop};
    assign o_Event_DV = (count != 2'd0);
    assign o_Event_Byte = fifo0;

    // Next state and the event byte to push; a release beats the long threshold on the same edge
    always_comb begin
        state_nx = state;
        push = 1'b0;
        push_byte = 8'h00;
        case (state)
            IDLE: if (rise) begin
                state_nx = HELD_SHORT;
                push = 1'b1;
                push_byte = 8'h50;
            end
            HELD_SHORT: if (fall) begin
                state_nx = IDLE;
                push = 1'b1;
                push_byte = 8'h53;
            end else if (threshold) begin
                state_nx = HELD_LONG;
                push = 1'b1;
                push_byte = 8'h4C;
            end
            HELD_LONG: if (fall) begin
                state_nx = IDLE;
                push = 1'b1;
                push_byte = 8'h52;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, edge-detect history, pulses, long-press level and press counter
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
            prev <= 1'b0;
            o_Press_Pulse <= 1'b0;
            o_Release_Pulse <= 1'b0;
            o_Long_Press <= 1'b0;
            o_Press_Count <= 8'h00;
        end else begin
            state <= state_nx;
            prev <= i_Switch;
            o_Press_Pulse <= rise;
            o_Release_Pulse <= fall;
            o_Long_Press <= (state_nx == HELD_LONG);
            if (state == IDLE && rise) o_Press_Count <= o_Press_Count + 8'd1;
        end
    end

    // Hold-time timebase: restarts on a press, runs while short-held, frozen otherwise
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            presc <= '0;
            ms_count <= 16'd0;
        end else if (state == IDLE && rise) begin
            presc <= '0;
            ms_count <= 16'd0;
        end else if (state == HELD_SHORT) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            ms_count <= (presc == PRESC_LAST) ? ms_count + 16'd1 : ms_count;
        end
    end

    // Two-entry shift FIFO: pop is applied first so a full FIFO can take a push on a popping edge
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            fifo0 <= 8'h00;
            fifo1 <= 8'h00;
            count <= 2'd0;
            o_Overflow <= 1'b0;
        end else begin
            if (pop) fifo0 <= fifo1;
            if (accept && level == 2'd0) fifo0 <= push_byte;
            if (accept && level == 2'd1) fifo1 <= push_byte;
            count <= level + {1'b0, accept};
            o_Overflow <= drop ? 1'b1 : (i_Clear_Overflow ? 1'b0 : o_Overflow);
        end
    end
endmodule

// File: tb/tb_switch_event_reporter.sv
// tb_switch_event_reporter: directed checks of events, timing, FIFO and overflow behaviour
module tb_switch_event_reporter;
    logic clk = 1'b0;
    logic rst_n, sw, rdy, clr;
    logic pp, rp, lp, dv, ovf;
    logic [7:0] ev_byte, cnt;
    logic [7:0] log_b[$];
    int log_c[$];
    int cyc = 0;
    int lp_cnt = 0;
    int mark = 0;
    int n_checks = 0;
    int n_pass = 0;

    switch_event_reporter #(.CLKS_PER_MS(10), .LONG_PRESS_MS(3)) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_Switch(sw),
        .o_Press_Pulse(pp),
        .o_Release_Pulse(rp),
        .o_Long_Press(lp),
        .o_Event_DV(dv),
        .o_Event_Byte(ev_byte),
        .i_Event_Ready(rdy),
        .o_Overflow(ovf),
        .i_Clear_Overflow(clr),
        .o_Press_Count(cnt)
    );

    always #5 clk = ~clk;

    // Log every transferred byte with its edge index and count long-press cycles
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dv && rdy) begin
            log_b.push_back(ev_byte);
            log_c.push_back(cyc);
        end
        if (lp) lp_cnt <= lp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_log(input string tag, input int n, input logic [31:0] exp);
        check({tag, "_len"}, log_b.size() - mark, n);
        for (int i = 0; i < n; i++)
            check(tag, (mark + i < log_b.size()) ? 32'(log_b[mark + i]) : 32'h100, 32'(exp[8*(n-1-i) +: 8]));
        mark = log_b.size();
    endtask

    initial begin
        int p_idx;
        int lp0;
        rst_n = 1'b0; sw = 1'b0; rdy = 1'b1; clr = 1'b0;
        repeat (3) tick();
        check("rst_dv", dv, 0);
        check("rst_byte", ev_byte, 0);
        check("rst_lp", lp, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cnt", cnt, 0);
        check("rst_pulses", {pp, rp}, 0);
        rst_n = 1'b1;
        tick();
        // 1: short press
        sw = 1'b1;
        tick();
        check("t1_pp_hi", pp, 1);
        tick();
        check("t1_pp_lo", pp, 0);
        repeat (8) tick();
        sw = 1'b0;
        tick();
        check("t1_rp_hi", rp, 1);
        tick();
        check("t1_rp_lo", rp, 0);
        repeat (4) tick();
        expect_log("t1", 2, 32'h5053);
        check("t1_cnt", cnt, 1);
        check("t1_lp_never", lp_cnt, 0);
        // 2: long press of 40 clocks
        p_idx = log_b.size();
        sw = 1'b1;
        tick();
        repeat (29) tick();
        check("t2_lp_e29", lp, 0);
        tick();
        check("t2_lp_e30", lp, 1);
        repeat (9) tick();
        check("t2_lp_e39", lp, 1);
        sw = 1'b0;
        tick();
        check("t2_lp_rel", lp, 0);
        repeat (4) tick();
        check("t2_latency", (log_b.size() >= p_idx + 2) ? log_c[p_idx+1] - log_c[p_idx] : -1, 30);
        expect_log("t2", 3, 32'h504C52);
        check("t2_cnt", cnt, 2);
        // 3: release on the threshold edge
        lp0 = lp_cnt;
        sw = 1'b1;
        tick();
        repeat (29) tick();
        sw = 1'b0;
        tick();
        check("t3_lp", lp, 0);
        repeat (4) tick();
        check("t3_lp_never", lp_cnt - lp0, 0);
        expect_log("t3", 2, 32'h5053);
        // 4: overflow with consumer stalled
        rdy = 1'b0;
        repeat (3) begin
            sw = 1'b1;
            repeat (5) tick();
            sw = 1'b0;
            repeat (5) tick();
        end
        check("t4_dv", dv, 1);
        check("t4_byte", ev_byte, 8'h50);
        check("t4_ovf", ovf, 1);
        check("t4_cnt", cnt, 6);
        tick();
        check("t4_byte_hold", ev_byte, 8'h50);
        rdy = 1'b1;
        repeat (4) tick();
        expect_log("t4", 2, 32'h5053);
        check("t4_dv_empty", dv, 0);
        check("t4_ovf_sticky", ovf, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_ovf_clr", ovf, 0);
        // 5: push into a full FIFO on a popping edge
        rdy = 1'b0;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        tick();
        check("t5_full_dv", dv, 1);
        rdy = 1'b1;
        sw = 1'b1;
        tick();
        check("t5_ovf_push", ovf, 0);
        repeat (3) tick();
        sw = 1'b0;
        repeat (4) tick();
        expect_log("t5", 4, 32'h50535053);
        check("t5_ovf", ovf, 0);
        check("t5_cnt", cnt, 8);
        // 6: asynchronous reset mid-hold
        rdy = 1'b0;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        tick();
        sw = 1'b1;
        tick();
        repeat (14) tick();
        check("t6_pre_dv", dv, 1);
        check("t6_pre_ovf", ovf, 1);
        check("t6_pre_cnt", cnt, 10);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dv", dv, 0);
        check("t6_rst_lp", lp, 0);
        check("t6_rst_cnt", cnt, 0);
        check("t6_rst_ovf", ovf, 0);
        check("t6_rst_byte", ev_byte, 0);
        rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_pp", pp, 1);
        check("t6_post_cnt", cnt, 1);
        repeat (3) tick();
        expect_log("t6", 1, 32'h50);
        sw = 1'b0;
        repeat (4) tick();
        expect_log("t6_rel", 1, 32'h53);
        // 7: press counter wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        repeat (255) begin
            sw = 1'b1;
            repeat (2) tick();
            sw = 1'b0;
            repeat (2) tick();
        end
        check("t7_cnt_255", cnt, 255);
        sw = 1'b1;
        repeat (2) tick();
        sw = 1'b0;
        repeat (2) tick();
        check("t7_cnt_wrap", cnt, 0);
        check("t7_ovf", ovf, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
